// File: rtl/duc_core_if.sv
// Streaming bus of the digital up-converter: NCO configuration, complex
// baseband input and real output with its sticky saturation flag.
interface duc_core_if;
   logic [47:0]        phase_in;
   logic               phase_valid;
   logic               resync;
   logic [63:0]        data_in;
   logic               valid_in;
   logic signed [31:0] data_out;
   logic               valid_out;
   logic               sat_flag;

   modport master (
      output phase_in, phase_valid, resync, data_in, valid_in,
      input  data_out, valid_out, sat_flag
   );

   modport slave (
      input  phase_in, phase_valid, resync, data_in, valid_in,
      output data_out, valid_out, sat_flag
   );
endinterface

// File: rtl/duc_core.sv
// Digital up-converter: mixes a complex I/Q stream with an internal NCO and
// emits y = (I*cos - Q*sin) >>> (LUT_W-1), saturated to 32 bits, 5 cycles later.
module duc_core #(
   parameter int PH_W   = 20,
   parameter int LUT_AW = 10,
   parameter int LUT_W  = 16
) (
   input  logic       clk,
   input  logic       rst,
   duc_core_if.slave  bus
);
   localparam int  TAB_N = 1 << LUT_AW;
   localparam int  P_W   = 32 + LUT_W;
   localparam real PI    = 3.14159265358979323846;
   localparam real AMP   = real'((1 << (LUT_W - 1)) - 1);

   // Full-wave sine/cosine tables, rounded to nearest at elaboration.
   logic signed [LUT_W-1:0] sin_rom [TAB_N];
   logic signed [LUT_W-1:0] cos_rom [TAB_N];

   for (genvar k = 0; k < TAB_N; k++) begin : g_rom
      localparam real ANG = 2.0 * PI * real'(k) / real'(TAB_N);
      localparam real SV  = AMP * $sin(ANG);
      localparam real CV  = AMP * $cos(ANG);
      localparam int  SI  = (SV >= 0.0) ? $rtoi(SV + 0.5) : $rtoi(SV - 0.5);
      localparam int  CI  = (CV >= 0.0) ? $rtoi(CV + 0.5) : $rtoi(CV - 0.5);
      assign sin_rom[k] = SI[LUT_W-1:0];
      assign cos_rom[k] = CI[LUT_W-1:0];
   end

   logic [PH_W-1:0]   pinc, poff, acc;
   logic [PH_W-1:0]   ph_sum;
   logic [LUT_AW-1:0] addr0;

   // A resync sample sees a cleared accumulator but the current poff.
   assign ph_sum = (bus.resync ? '0 : acc) + poff;
   assign addr0  = ph_sum[PH_W-1 -: LUT_AW];

   // NOTE: registered state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         pinc <= '0;
         poff <= '0;
         acc  <= '0;
      end else begin
         if (bus.phase_valid) begin
            pinc <= bus.phase_in[PH_W-1:0];
            poff <= bus.phase_in[24 +: PH_W];
         end
         if (bus.resync)
            acc <= bus.valid_in ? pinc : '0;
         else if (bus.valid_in)
            acc <= acc + pinc;
      end
   end

   logic                    v1, v2, v3, v4;
   logic [LUT_AW-1:0]       addr1;
   logic signed [31:0]      i1, q1, i2, q2;
   logic signed [LUT_W-1:0] cos2, sin2;
   logic signed [P_W-1:0]   p_ic, p_qs;
   logic signed [P_W:0]     diff4;
   logic signed [P_W:0]     sh;
   logic                    in_range;
   logic signed [31:0]      sat_val;

   // NOTE: every output of this block gets a value on every path, so no
   // latch is inferred.
   always_comb begin
      sh       = diff4 >>> (LUT_W - 1);
      in_range = (&sh[P_W:31]) || !(|sh[P_W:31]);
      sat_val  = sh[31:0];
      if (!in_range)
         sat_val = sh[P_W] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
   end

   // NOTE: the ROM arrays are elaboration constants and take no reset; only
   // the registers holding their read data are cleared.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1            <= 1'b0;
         addr1         <= '0;
         i1            <= '0;
         q1            <= '0;
         v2            <= 1'b0;
         cos2          <= '0;
         sin2          <= '0;
         i2            <= '0;
         q2            <= '0;
         v3            <= 1'b0;
         p_ic          <= '0;
         p_qs          <= '0;
         v4            <= 1'b0;
         diff4         <= '0;
         bus.valid_out <= 1'b0;
         bus.data_out  <= '0;
         bus.sat_flag  <= 1'b0;
      end else begin
         v1    <= bus.valid_in;
         addr1 <= addr0;
         i1    <= bus.data_in[31:0];
         q1    <= bus.data_in[63:32];

         v2    <= v1;
         cos2  <= cos_rom[addr1];
         sin2  <= sin_rom[addr1];
         i2    <= i1;
         q2    <= q1;

         v3    <= v2;
         p_ic  <= P_W'(i2) * P_W'(cos2);
         p_qs  <= P_W'(q2) * P_W'(sin2);

         v4    <= v3;
         diff4 <= $signed({p_ic[P_W-1], p_ic}) - $signed({p_qs[P_W-1], p_qs});

         bus.valid_out <= v4;
         if (v4) begin
            bus.data_out <= sat_val;
            if (!in_range)
               bus.sat_flag <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_duc_core.sv
// Directed bench for duc_core: tones at 0/90/180/270 degrees, saturation,
// bursty input with a mid-stream step change, and reset with samples in flight.
module tb_duc_core;
   logic clk = 1'b0;
   logic rst = 1'b1;

   duc_core_if bus ();

   duc_core dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   logic signed [31:0] out_q [$];
   int                 out_cyc [$];
   int                 in_cyc [$];

   int e2 [8] = '{999, 0, -1000, 0, 999, 0, -1000, 0};
   int e5 [9] = '{999, 0, -1000, 0, 999, -1000, 999, -1000, 999};

   always @(negedge clk) begin
      if (bus.valid_out === 1'b1) begin
         out_q.push_back(bus.data_out);
         out_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick(input logic v, input logic [31:0] i, input logic [31:0] q,
                       input logic pv, input logic rs,
                       input logic [19:0] pinc, input logic [19:0] poff);
      @(negedge clk);
      bus.valid_in    = v;
      bus.data_in     = {q, i};
      bus.phase_valid = pv;
      bus.resync      = rs;
      bus.phase_in    = {4'b0, poff, 4'b0, pinc};
      if (v && !rst) in_cyc.push_back(cyc);
   endtask

   task automatic samp(input logic [31:0] i, input logic [31:0] q);
      tick(1'b1, i, q, 1'b0, 1'b0, 20'h0, 20'h0);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 20'h0, 20'h0);
   endtask

   task automatic cfg(input logic [19:0] pinc, input logic [19:0] poff);
      tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, pinc, poff);
   endtask

   task automatic expect_out(input string tag, input logic signed [31:0] exp);
      logic signed [31:0] got;
      int lat;
      got = 'x;
      lat = -1;
      if (out_q.size() > 0) got = out_q.pop_front();
      if (out_cyc.size() > 0 && in_cyc.size() > 0) lat = out_cyc.pop_front() - in_cyc.pop_front();
      check(tag, got, exp);
      check({tag, " latency"}, lat, 5);
   endtask

   initial begin
      bus.phase_in    = '0;
      bus.phase_valid = 1'b0;
      bus.resync      = 1'b0;
      bus.data_in     = '0;
      bus.valid_in    = 1'b0;

      idle(3);
      check("reset valid_out", bus.valid_out, 0);
      check("reset data_out", bus.data_out, 0);
      check("reset sat_flag", bus.sat_flag, 0);
      rst = 1'b0;

      // DC: cos(0) gain of 32767/32768 floors 1000 down to 999
      cfg(20'h0, 20'h0);
      for (int k = 0; k < 6; k++) samp(32'd1000, 32'd0);
      idle(8);
      check("t1 count", out_q.size(), 6);
      for (int k = 0; k < 6; k++) expect_out("t1 dc", 999);

      // Quarter-turn step: cos walks 0, 90, 180, 270 degrees
      cfg(20'h40000, 20'h0);
      for (int k = 0; k < 8; k++) samp(32'd1000, 32'd0);
      idle(8);
      check("t2 count", out_q.size(), 8);
      for (int k = 0; k < 8; k++) expect_out($sformatf("t2 step%0d", k), e2[k]);

      cfg(20'h0, 20'h40000);
      for (int k = 0; k < 4; k++) samp(32'd0, 32'd1000);
      idle(8);
      check("t3 count", out_q.size(), 4);
      for (int k = 0; k < 4; k++) expect_out("t3 q90", -1000);
      check("t3 sat_flag", bus.sat_flag, 0);

      cfg(20'h0, 20'h20000);
      for (int k = 0; k < 2; k++) samp(32'h7FFF_FFFF, 32'h8000_0000);
      idle(8);
      check("t4 count", out_q.size(), 2);
      for (int k = 0; k < 2; k++) expect_out("t4 sat", 32'sh7FFF_FFFF);
      check("t4 sat_flag", bus.sat_flag, 1);
      idle(4);
      check("t4 sat_flag held", bus.sat_flag, 1);

      // Bursts 3 on / 2 off; the 4th sample carries the pinc change itself
      cfg(20'h40000, 20'h0);
      for (int k = 0; k < 3; k++) samp(32'd1000, 32'd0);
      idle(2);
      tick(1'b1, 32'd1000, 32'd0, 1'b1, 1'b0, 20'h80000, 20'h0);
      for (int k = 0; k < 2; k++) samp(32'd1000, 32'd0);
      idle(2);
      for (int k = 0; k < 3; k++) samp(32'd1000, 32'd0);
      idle(8);
      check("t5 count", out_q.size(), 9);
      for (int k = 0; k < 9; k++) expect_out($sformatf("t5 step%0d", k), e5[k]);
      check("t5 sat_flag", bus.sat_flag, 1);

      // One-cycle reset with three samples in flight; inputs during reset are ignored
      cfg(20'h0, 20'h0);
      for (int k = 0; k < 3; k++) samp(32'd1000, 32'd0);
      @(negedge clk);
      rst             = 1'b1;
      bus.valid_in    = 1'b1;
      bus.phase_valid = 1'b1;
      bus.resync      = 1'b1;
      bus.phase_in    = {4'b0, 20'h40000, 4'b0, 20'h40000};
      @(negedge clk);
      rst             = 1'b0;
      bus.valid_in    = 1'b0;
      bus.phase_valid = 1'b0;
      bus.resync      = 1'b0;
      in_cyc.delete();
      check("t6 valid_out", bus.valid_out, 0);
      check("t6 data_out", bus.data_out, 0);
      check("t6 sat_flag", bus.sat_flag, 0);
      idle(8);
      check("t6 no stale", out_q.size(), 0);
      samp(32'd1000, 32'd0);
      idle(8);
      check("t6 count", out_q.size(), 1);
      expect_out("t6 first", 999);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
